count_snapshot_fifo: RTL and testbench

- Downstream consumer of the free-running WIDTH-bit event counter.
- Samples the counter value on a capture strobe and buffers snapshots in a small FIFO.
- Drains the FIFO over a valid/ready interface to a register/readout stage.
- Flags lost captures with a sticky overflow bit.

---
 rtl/count_snapshot_pkg.sv | 18 +
 rtl/count_snapshot_fifo_fifo.sv | 80 ++++++++
 rtl/count_snapshot_fifo.sv | 87 ++++++++
 tb/tb_count_snapshot_fifo.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/count_snapshot_pkg.sv
// Shared constants, width helpers and snapshot type for the counter snapshot FIFO.
package count_snapshot_pkg;

    localparam int unsigned DefaultWidth = 8;
    localparam int unsigned DefaultDepth = 4;

    // A depth of 1 would give a zero-width pointer, so clamp to one bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int unsigned lvl_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    typedef logic [DefaultWidth-1:0] snapshot_t;

endpackage

// File: rtl/count_snapshot_fifo_fifo.sv
// Generic synchronous FIFO: power-of-two storage, wrapping pointers, separate level count.
module snapshot_fifo
    import count_snapshot_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned DEPTH = DefaultDepth
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push_i,
    input  logic [WIDTH-1:0]              data_i,
    input  logic                          pop_i,
    output logic                          accept_o,
    output logic [WIDTH-1:0]              data_o,
    output logic                          valid_o,
    output logic [lvl_width(DEPTH)-1:0]   level_o
);

    localparam int unsigned PtrW = ptr_width(DEPTH);
    localparam int unsigned LvlW = lvl_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]  level_q, level_d;
    logic             valid_q, valid_d;
    logic             full;
    logic             pop_ok;
    logic             push_ok;

    assign full    = (level_q == LvlW'(DEPTH));
    // Popping while empty is impossible: out_ready is ignored without valid.
    assign pop_ok  = pop_i && valid_q;
    assign push_ok = push_i && (!full || pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LvlW'(1);
            2'b01:   level_d = level_q - LvlW'(1);
            default: level_d = level_q;
        endcase
        valid_d = (level_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            valid_q  <= valid_d;
        end
    end

    assign accept_o = push_ok;
    assign data_o   = mem_q[rd_ptr_q];
    assign valid_o  = valid_q;
    assign level_o  = level_q;

endmodule

// File: rtl/count_snapshot_fifo.sv
// Counter snapshot capture with FIFO buffering and sticky overflow.
// Define COUNT_SNAPSHOT_DELTA_EN to store intervals between accepted captures instead of raw values.
module count_snapshot_fifo
    import count_snapshot_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned DEPTH = DefaultDepth
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [WIDTH-1:0]            cnt_in,
    input  logic                        capture,
    output logic [WIDTH-1:0]            out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [lvl_width(DEPTH)-1:0] level,
    output logic                        overflow,
    input  logic                        clr_ovf
);

    logic [WIDTH-1:0] push_data;
    logic             accept;
    logic             drop;
    logic             overflow_q, overflow_d;

    snapshot_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_i   (capture),
        .data_i   (push_data),
        .pop_i    (out_ready),
        .accept_o (accept),
        .data_o   (out_data),
        .valid_o  (out_valid),
        .level_o  (level)
    );

`ifdef COUNT_SNAPSHOT_DELTA_EN
    logic [WIDTH-1:0] prev_cap_q, prev_cap_d;

    // Dropped captures must not advance the reference, so deltas sum to elapsed count.
    always_comb begin
        prev_cap_d = prev_cap_q;
        if (accept) begin
            prev_cap_d = cnt_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_cap_q <= '0;
        end else begin
            prev_cap_q <= prev_cap_d;
        end
    end

    assign push_data = cnt_in - prev_cap_q;
`else
    assign push_data = cnt_in;
`endif

    assign drop = capture && !accept;

    // A fresh drop beats a simultaneous clear.
    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;

endmodule

// File: tb/tb_count_snapshot_fifo.sv
// Scoreboard bench for count_snapshot_fifo: directed scenarios plus random traffic.
module tb_count_snapshot_fifo;
    import count_snapshot_pkg::*;

    localparam int unsigned WIDTH = DefaultWidth;
    localparam int unsigned DEPTH = DefaultDepth;
    localparam int unsigned LVLW  = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] cnt_in;
    logic             capture;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [LVLW-1:0]  level;
    logic             overflow;
    logic             clr_ovf;

    count_snapshot_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cnt_in    (cnt_in),
        .capture   (capture),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    always #5 clk = ~clk;

    int        tests = 0;
    int        fails = 0;
    snapshot_t sb[$];
    int        m_level;
    bit        m_ovf;
    snapshot_t m_prev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_level = 0;
        m_ovf   = 1'b0;
        m_prev  = '0;
    endtask

    // Called at posedge+1: checks the state predicted last cycle, drives, predicts the next.
    task automatic step(input bit cap, input snapshot_t val, input bit rdy, input bit clr);
        bit pop;
        bit acc;
        chk("level", 32'(level), 32'(m_level));
        chk("out_valid", 32'(out_valid), 32'(m_level != 0));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        capture   = cap;
        cnt_in    = val;
        out_ready = rdy;
        clr_ovf   = clr;
        pop = rdy && (m_level != 0);
        acc = cap && ((m_level < int'(DEPTH)) || pop);
        if (acc) begin
`ifdef COUNT_SNAPSHOT_DELTA_EN
            sb.push_back(val - m_prev);
`else
            sb.push_back(val);
`endif
            m_prev = val;
        end
        m_level = m_level + int'(acc) - int'(pop);
        if (cap && !acc) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        capture   = 1'b0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        cnt_in    = '0;
        #2;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < int'(DEPTH) + 2; i++) step(1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b1;
        capture   = 1'b0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        cnt_in    = '0;
        model_reset();
        #1;
        rst_n = 1'b0;

        // Monitor: head must match the scoreboard whenever valid; a handshake consumes it.
        fork
            forever begin
                @(negedge clk);
                if (rst_n && out_valid) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_valid", 32'(out_valid), 32'd0);
                    end else begin
                        chk("out_data", 32'(out_data), 32'(sb[0]));
                        if (out_ready) void'(sb.pop_front());
                    end
                end
            end
        join_none

        @(posedge clk);
        #1;
        do_reset();

        // Single capture, then pop.
        step(1'b1, 8'h05, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // Fill and drop the fifth.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        // Full with simultaneous pop: accepted.
        step(1'b1, 8'h20, 1'b1, 1'b0);
        // Drop with clear in the same cycle: set wins; then clear alone.
        step(1'b1, 8'h30, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        drain();

        // Reset mid-stream.
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        do_reset();
        step(1'b1, 8'h07, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        drain();

        // Wrap-around pair (delta build yields F0 then 20).
        do_reset();
        step(1'b1, 8'hF0, 1'b0, 1'b0);
        step(1'b1, 8'h10, 1'b0, 1'b0);
        drain();

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            step(($urandom % 3) != 0, 8'($urandom), 1'($urandom % 2), ($urandom % 16) == 0);
        end
        drain();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
